// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - multi-beat wide add/subtract on one shared 16-bit CLA
// Operands are consumed one 16-bit word per cycle, LSW first, with the carry registered between beats.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [16:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end

    // Second-level lookahead: every group carry is a flat function of ci.
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[16] = gc[4];

    sum = p ^ c[15:0];
    co  = c[16];
  end

endmodule

module cla_word_sequencer #(
  parameter int WORDS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic              co,
  output logic              ovf,
  output logic              busy
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  beff_reg;
  logic          carry;
  logic [IW-1:0] idx;

  logic [15:0]   word_a;
  logic [15:0]   word_b;
  logic [15:0]   word_sum;
  logic          word_co;
  logic          last_beat;

  assign word_a    = a_reg[16*idx +: 16];
  assign word_b    = beff_reg[16*idx +: 16];
  assign last_beat = (idx == IW'(WORDS - 1));
  assign in_ready  = (state == IDLE) & rst_n;

  cla16 u_cla (
    .a   (word_a),
    .b   (word_b),
    .ci  (carry),
    .sum (word_sum),
    .co  (word_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      beff_reg  <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtraction is A + ~B + 1: invert B here and inject the +1 as the first carry-in.
            a_reg    <= a;
            beff_reg <= b ^ {W{sub}};
            carry    <= sub;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[16*idx +: 16] <= word_sum;
          carry             <= word_co;
          idx               <= idx + 1'b1;
          if (last_beat) begin
            co        <= word_co;
            ovf       <= (a_reg[W-1] == beff_reg[W-1]) && (word_sum[15] != a_reg[W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb/tb_cla_word_sequencer.sv - self-checking bench for cla_word_sequencer (WORDS=2)

module tb_cla_word_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        co;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_word_sequencer #(.WORDS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference in plain integer arithmetic: modular result, unsigned carry/no-borrow, signed range.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic msub);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint r;
    logic [31:0] s;
    logic c;
    logic v;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      s = ma - mb;
      c = (ua >= ub);
      r = sa - sb;
    end else begin
      s = ma + mb;
      c = (ua + ub) > 64'sd4294967295;
      r = sa + sb;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {v, c, s};
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       output logic [31:0] rs, output logic rc, output logic ro, output int lat);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    sub = ts;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = sum;
    rc = co;
    ro = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    chk("out_valid_after_handshake", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rs;
    logic        rc;
    logic        ro;
    int          lat;
    logic [33:0] m;
    logic [31:0] held;
    logic [31:0] specials[6];

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[7] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

    specials[0] = 32'h00000000;
    specials[1] = 32'hFFFFFFFF;
    specials[2] = 32'h0000FFFF;
    specials[3] = 32'h7FFFFFFF;
    specials[4] = 32'h80000000;
    specials[5] = 32'hFFFF0000;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;

    repeat (2) begin
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_sum", 64'(sum), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].sum));
      chk($sformatf("vec%0d_co", i), 64'(rc), 64'(vecs[i].co));
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ovf));
    end

    // Backpressure: result must hold while new operands wait outside IDLE.
    @(negedge clk);
    a = 32'h0001FFFF;
    b = 32'h0000FFFF;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'h01234567;
    sub = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd2);
    held = sum;
    chk("bp_sum", 64'(held), 64'h0002FFFE);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
      chk("bp_sum_held", 64'(sum), 64'h0002FFFE);
      chk("bp_co_held", 64'(co), 64'd0);
      chk("bp_ovf_held", 64'(ovf), 64'd0);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_valid_dropped", 64'(out_valid), 64'd0);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    chk("bp_new_op_not_taken", 64'(busy), 64'd0);
    do_op(32'hDEADBEEF, 32'h01234567, 1'b1, rs, rc, ro, lat);
    chk("bp_next_sum", 64'(rs), 64'hDD8A7988);
    chk("bp_next_co", 64'(rc), 64'd1);

    // Reset during the second beat discards the partial result.
    @(negedge clk);
    a = 32'h0000FFFF;
    b = 32'h00000001;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_result", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
    end
    do_op(32'h12345678, 32'h11111111, 1'b0, rs, rc, ro, lat);
    chk("midrst_next_sum", 64'(rs), 64'h23456789);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rsub;
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rsub = 1'($urandom);
      m = model(ra, rb, rsub);
      do_op(ra, rb, rsub, rs, rc, ro, lat);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("rnd%0d_sum a=%h b=%h s=%0d", i, ra, rb, rsub), 64'(rs), 64'(m[31:0]));
      chk($sformatf("rnd%0d_co", i), 64'(rc), 64'(m[32]));
      chk($sformatf("rnd%0d_ovf", i), 64'(ro), 64'(m[33]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
